// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - ALU initiator: decodes RV32I OP/OP-IMM, drives the ALU, returns the result.
// Optional out_zero result flag is enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_seq #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic [31:0] alu_d1,
    output logic [31:0] alu_d2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic        out_zero,
`endif
    output logic        out_illegal
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] d1_q, d1_d, d2_q, d2_d, result_q, result_d;
    logic [3:0]  ctrl_q, ctrl_d, cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d, zero_q, zero_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_d2;
    logic        wait_done;
    logic        unused_reg_fields;

    assign opcode            = in_instr[6:0];
    assign funct3            = in_instr[14:12];
    assign funct7            = in_instr[31:25];
    assign unused_reg_fields = ^in_instr[19:15];
    assign wait_done         = alu_ready || (cnt_q == CNT_LAST);

    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = 4'b0000;
        dec_d2    = in_rs2;
        case (opcode)
            7'b0110011: begin
                dec_ctrl  = {funct7[5], funct3};
                dec_legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            7'b0010011: begin
                dec_d2 = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b001: begin
                        dec_ctrl  = 4'b0001;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_ctrl  = {funct7[5], 3'b101};
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: begin
                        // No immediate subtract exists, so funct7 never selects SUB here.
                        dec_ctrl  = {1'b0, funct3};
                        dec_legal = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            d1_q      <= '0;
            d2_q      <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = dec_legal ? S_ISSUE : S_DONE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_done) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        d1_d      = d1_q;
        d2_d      = d2_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        zero_d    = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d      = in_instr[11:7];
                    illegal_d = !dec_legal;
                    // Illegal encodings leave the ALU-facing registers untouched.
                    if (dec_legal) begin
                        d1_d   = in_rs1;
                        d2_d   = dec_d2;
                        ctrl_d = dec_ctrl;
                    end else begin
                        result_d = '0;
                        zero_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: cnt_d = '0;
            S_WAIT: begin
                if (wait_done) begin
                    result_d = alu_result;
                    zero_d   = (alu_result == 32'h0);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign alu_d1      = d1_q;
    assign alu_d2      = d2_q;
    assign alu_control = ctrl_q;
    assign out_result  = result_q;
    assign out_rd      = rd_q;
    assign out_illegal = illegal_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign out_zero    = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule
